// File: rtl/execute_pipe.sv
// Registered MIPS execute stage: single-cycle ALU ops plus an iterative
// shift-add multiplier / restoring divider behind valid/ready handshakes.
module execute_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] immediate,
  input  logic             ALUsrc,
  input  logic [3:0]       ALU_control_lines,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             is_div_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH-1:0] b_sel_s;
  logic             accept_s;
  logic             is_multi_s;
  logic [WIDTH-1:0] add_s;
  logic [WIDTH-1:0] sub_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH-1:0] step_hi_s;
  logic [WIDTH-1:0] step_lo_s;
  logic [WIDTH-1:0] fin_res_s;
  logic [WIDTH-1:0] fin_hi_s;
  logic             fin_dbz_s;

  // Ready is a pure function of state and downstream ready, never of in_valid.
  always_comb begin
    in_ready   = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && out_ready);
    accept_s   = in_valid && in_ready;
    b_sel_s    = ALUsrc ? immediate : read_data2;
    is_multi_s = (ALU_control_lines == OP_MULTU) || (ALU_control_lines == OP_DIVU);
    add_s      = read_data1 + b_sel_s;
    sub_s      = read_data1 - b_sel_s;
  end

  // Single-cycle ALU result and signed overflow for the presented operation.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    case (ALU_control_lines)
      OP_AND: alu_res_s = read_data1 & b_sel_s;
      OP_OR:  alu_res_s = read_data1 | b_sel_s;
      OP_NOR: alu_res_s = ~(read_data1 | b_sel_s);
      OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(read_data1) < $signed(b_sel_s))};
      OP_ADD: begin
        alu_res_s = add_s;
        alu_ovf_s = (read_data1[WIDTH-1] == b_sel_s[WIDTH-1]) &&
                    (add_s[WIDTH-1] != read_data1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = sub_s;
        alu_ovf_s = (read_data1[WIDTH-1] != b_sel_s[WIDTH-1]) &&
                    (sub_s[WIDTH-1] != read_data1[WIDTH-1]);
      end
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  // One engine iteration; hi_r holds partial product or running remainder.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    if (is_div_r) begin
      if (div_shift_s >= {1'b0, b_r}) begin
        // Remainder stays below B, so the low-bit difference is exact.
        step_hi_s = div_shift_s[WIDTH-1:0] - b_r;
        step_lo_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_s = div_shift_s[WIDTH-1:0];
        step_lo_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Values registered on the final engine iteration.
  always_comb begin
    fin_res_s = step_lo_s;
    fin_hi_s  = step_hi_s;
    fin_dbz_s = 1'b0;
    if (is_div_r && (b_r == {WIDTH{1'b0}})) begin
      fin_res_s = {WIDTH{1'b1}};
      fin_hi_s  = a_r;
      fin_dbz_s = 1'b1;
    end else begin
      fin_dbz_s = 1'b0;
    end
  end

  // Stage FSM, engine registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      is_div_r    <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      out_valid   <= 1'b0;
      ALU_result  <= {WIDTH{1'b0}};
      result_hi   <= {WIDTH{1'b0}};
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_HOLD: begin
          if (accept_s) begin
            if (is_multi_s) begin
              is_div_r  <= (ALU_control_lines == OP_DIVU);
              a_r       <= read_data1;
              b_r       <= b_sel_s;
              hi_r      <= {WIDTH{1'b0}};
              lo_r      <= read_data1;
              cnt_r     <= CW'(WIDTH);
              out_valid <= 1'b0;
              state_r   <= ST_BUSY;
            end else begin
              ALU_result  <= alu_res_s;
              result_hi   <= {WIDTH{1'b0}};
              zero        <= (alu_res_s == {WIDTH{1'b0}});
              overflow    <= alu_ovf_s;
              div_by_zero <= 1'b0;
              out_valid   <= 1'b1;
              state_r     <= ST_HOLD;
            end
          end else if ((state_r == ST_HOLD) && out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        ST_BUSY: begin
          hi_r  <= step_hi_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            ALU_result  <= fin_res_s;
            result_hi   <= fin_hi_s;
            zero        <= (fin_res_s == {WIDTH{1'b0}});
            overflow    <= 1'b0;
            div_by_zero <= fin_dbz_s;
            out_valid   <= 1'b1;
            state_r     <= ST_HOLD;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed-vector bench for execute_pipe at WIDTH=32 with hand-computed results.
module tb_execute_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] read_data1 = '0;
  logic [W-1:0] read_data2 = '0;
  logic [W-1:0] immediate = '0;
  logic         ALUsrc = 1'b0;
  logic [3:0]   ALU_control_lines = 4'b0000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] ALU_result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         overflow;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  execute_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .read_data1(read_data1), .read_data2(read_data2), .immediate(immediate),
    .ALUsrc(ALUsrc), .ALU_control_lines(ALU_control_lines),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_result(ALU_result),
    .result_hi(result_hi), .zero(zero), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] res, input logic [W-1:0] hi,
                           input logic z, input logic ov, input logic dbz);
    check_val({tag, ".valid"}, 64'(out_valid), 64'd1);
    check_val({tag, ".res"}, 64'(ALU_result), 64'(res));
    check_val({tag, ".hi"}, 64'(result_hi), 64'(hi));
    check_val({tag, ".zero"}, 64'(zero), 64'(z));
    check_val({tag, ".ovf"}, 64'(overflow), 64'(ov));
    check_val({tag, ".dbz"}, 64'(div_by_zero), 64'(dbz));
  endtask

  // Present one operation at a negedge and hold it across the accepting posedge.
  task automatic issue(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] imm, input logic src);
    @(negedge clk);
    ALU_control_lines = code;
    read_data1 = a;
    read_data2 = b;
    immediate  = imm;
    ALUsrc     = src;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    read_data1 = 32'hDEAD_BEEF;
    read_data2 = 32'h1234_5678;
    immediate  = 32'h0BAD_F00D;
  endtask

  task automatic single(input string tag, input logic [3:0] code, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] imm, input logic src,
                        input logic [W-1:0] res, input logic z, input logic ov);
    issue(code, a, b, imm, src);
    @(negedge clk);
    check_res(tag, res, 32'h0, z, ov, 1'b0);
  endtask

  task automatic multi(input string tag, input logic [3:0] code, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic [W-1:0] hi,
                       input logic z, input logic dbz);
    int edges;
    int ready_seen;
    edges = -1;
    ready_seen = 0;
    issue(code, a, b, 32'h0, 1'b0);
    for (int i = 1; i <= W + 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        edges = i - 1;
        break;
      end else if (in_ready) begin
        ready_seen++;
      end
    end
    check_val({tag, ".latency"}, 64'(edges), 64'(W));
    check_val({tag, ".busy_ready"}, 64'(ready_seen), 64'd0);
    check_res(tag, res, hi, z, 1'b0, dbz);
  endtask

  initial begin
    #3;
    check_val("rst.valid", 64'(out_valid), 64'd0);
    check_val("rst.res", 64'(ALU_result), 64'd0);
    check_val("rst.ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    single("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    single("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    single("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    single("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h1, 1'b0, 1'b0);
    single("slt_no", 4'b0111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    single("nor", 4'b1100, 32'h0, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    single("and_imm", 4'b0000, 32'hFF, 32'hABCD, 32'h10, 1'b1, 32'h10, 1'b0, 1'b0);
    single("or", 4'b0001, 32'hF0, 32'h0F, 32'h0, 1'b0, 32'hFF, 1'b0, 1'b0);
    single("unknown", 4'b0011, 32'd5, 32'd6, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

    multi("mul_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    multi("mul_carry", 4'b1000, 32'h1_0000, 32'h1_0000, 32'h0, 32'h1, 1'b1, 1'b0);
    multi("div", 4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    multi("div_small", 4'b1001, 32'd7, 32'd100, 32'd0, 32'd7, 1'b1, 1'b0);
    multi("div_zero", 4'b1001, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1);
    single("after_div", 4'b0010, 32'd1, 32'd2, 32'h0, 1'b0, 32'd3, 1'b0, 1'b0);

    // Backpressure: result held while a second operation waits.
    single("bp_first", 4'b0010, 32'd10, 32'd20, 32'h0, 1'b0, 32'd30, 1'b0, 1'b0);
    out_ready = 1'b0;
    ALU_control_lines = 4'b0110;
    read_data1 = 32'd50;
    read_data2 = 32'd8;
    ALUsrc = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp.hold_res", 64'(ALU_result), 64'd30);
      check_val("bp.hold_valid", 64'(out_valid), 64'd1);
      check_val("bp.ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp.pass_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_res("bp_second", 32'd42, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a multiply discards it.
    issue(4'b1000, 32'd123, 32'd456, 32'h0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mrst.valid", 64'(out_valid), 64'd0);
    check_val("mrst.res", 64'(ALU_result), 64'd0);
    check_val("mrst.hi", 64'(result_hi), 64'd0);
    check_val("mrst.flags", 64'({zero, overflow, div_by_zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("mrst.ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk);
    check_val("mrst.idle_valid", 64'(out_valid), 64'd0);
    single("mrst_add", 4'b0010, 32'd3, 32'd4, 32'h0, 1'b0, 32'd7, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_pipe.md
# execute_pipe

Parametrised, registered execute stage for the MIPS datapath. It selects the second operand (register or immediate), performs single-cycle logic/arithmetic ops, and runs multi-cycle unsigned multiply and divide through an internal iterative engine. A valid/ready handshake on both sides lets the stage stall decode and be stalled by memory. It sits between register-read/decode and the memory stage.

## Interface
- WIDTH, 32, datapath width in bits (≥ 4)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  stage accepts operation this cycle
- read_data1  input  WIDTH  operand A
- read_data2  input  WIDTH  register operand B
- immediate  input  WIDTH  sign/zero-extended immediate
- ALUsrc  input  1  0: B = read_data2, 1: B = immediate
- ALU_control_lines  input  4  operation code
- out_valid  output  1  result registers hold a result
- out_ready  input  1  downstream consumes result
- ALU_result  output  WIDTH  primary result (low product / quotient)
- result_hi  output  WIDTH  high product / remainder; 0 for single-cycle ops
- zero  output  1  ALU_result == 0
- overflow  output  1  signed overflow (ADD/SUB only)
- div_by_zero  output  1  DIVU with B == 0

## Operation
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, 1000 MULTU, 1001 DIVU; any other code → ALU_result = 0, result_hi = 0, zero = 1, all flags 0.
- Operand B latched at acceptance from ALUsrc mux; inputs may change after the accept edge.
- ADD/SUB: modulo 2^WIDTH; overflow = operand signs agree (for SUB: A and ~B) and result sign differs.
- MULTU: 2·WIDTH-bit unsigned product, shift-add, one bit per cycle; {result_hi, ALU_result} = A×B.
- DIVU: restoring division, one quotient bit per cycle; ALU_result = A/B, result_hi = A mod B.
- DIVU by zero: ALU_result = all ones, result_hi = A, div_by_zero = 1; still takes full latency.
- FSM states: IDLE, BUSY, HOLD.
  - IDLE: in_ready = 1. Accept (in_valid & in_ready) of single-cycle op → result registered, out_valid = 1, → HOLD. Accept of MULTU/DIVU → load engine, counter = WIDTH, → BUSY.
  - BUSY: in_ready = 0; one iteration per cycle, counter decrements; on the edge where counter goes 1→0, results and flags registered, out_valid = 1, → HOLD.
  - HOLD: out_valid = 1, outputs stable. in_ready = out_ready (pass-through). If out_ready and no accept → IDLE, out_valid = 0. If out_ready and accept in same cycle → behaves as accept from IDLE (single-cycle: stay HOLD with new result; multi-cycle: → BUSY, out_valid = 0).
- in_ready never depends on in_valid.

## Timing
- Reset (rst_n low, any state, immediate): state IDLE, out_valid 0, ALU_result 0, result_hi 0, zero 0, overflow 0, div_by_zero 0, counter 0; in-flight operation discarded.
- Single-cycle op: out_valid rises on the accept edge (latency 1); back-to-back throughput 1 op/cycle with out_ready held high.
- MULTU/DIVU: out_valid rises WIDTH edges after the accept edge (latency WIDTH); throughput one per WIDTH+1 cycles.
- Outputs and flags change only on the edge that sets out_valid; unchanged while out_valid & !out_ready.
- zero/overflow/div_by_zero are registered alongside ALU_result, never combinational from inputs.

## Test plan
- Reset: assert rst_n low mid-BUSY of a MULTU → all outputs 0, in_ready 1 on release; next ADD 3+4 gives ALU_result 7 one cycle after accept.
- ALU ops, WIDTH=32, out_ready=1: ADD 0x7FFFFFFF+1 → 0x80000000, overflow 1; SUB 5−5 → 0, zero 1; SLT −1<1 → 1; NOR 0,0 → 0xFFFFFFFF; ALUsrc=1, immediate 0x10, AND 0xFF → 0x10.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → result_hi 0xFFFFFFFE, ALU_result 0x00000001 exactly 32 cycles after accept; in_ready 0 throughout BUSY.
- DIVU 100/7 → ALU_result 14, result_hi 2; DIVU 9/0 → ALU_result 0xFFFFFFFF, result_hi 9, div_by_zero 1.
- Backpressure: out_ready 0 for 5 cycles after an ADD result → outputs stable, in_ready 0, second op held; raise out_ready with in_valid → both transfer same cycle, new result next edge.
- Unknown code 0011 → ALU_result 0, zero 1, flags 0, latency 1.
